// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, constants and helpers.
//   state_t   : key-expansion FSM states
//   RCON_RST  : first round constant
//   nk_of/nr_of/nw_of : key words, rounds and schedule words for a key length
//   xtime     : multiply-by-x in GF(2^8)
package aes_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    localparam logic [7:0] RCON_RST = 8'h01;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int nw_of(input int key_bits);
        return 4 * (nr_of(key_bits) + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
//   a : input byte
//   y : substituted byte
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = TABLE[a];
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: word-serial AES-128/192/256 key schedule, one w[i] per handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   start, key_in       : begin expansion of key_in (sampled in IDLE only)
//   busy                : expansion in progress
//   rk_valid, rk_ready  : round-key word handshake
//   rk_word, rk_idx     : current word w[rk_idx]
//   done                : pulse on the handshake of the last word
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int IDX_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [31:0]         rk_word,
    output logic [IDX_W-1:0]    rk_idx,
    output logic                done
);
    localparam int NK = nk_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);

    state_t state, state_n;
    // Window holds w[idx .. idx+NK-1]; its top word is the word on offer.
    logic [KEY_BITS-1:0] win;
    logic [7:0] rcon;
    // pos = idx mod NK, which equals (idx+NK) mod NK for the word being built.
    logic [2:0] pos;
    logic xfer, last;
    logic [31:0] prev, rot, sub_in, sub, t, nxt;

    assign xfer     = rk_valid && rk_ready;
    assign last     = state == EXPAND && rk_idx == IDX_W'(NW - 1);
    assign rk_valid = state != IDLE;
    assign busy     = state != IDLE;
    assign rk_word  = win[KEY_BITS-1 -: 32];
    assign done     = xfer && last;

    assign prev   = win[31:0];
    assign rot    = {prev[23:0], prev[31:24]};
    assign sub_in = pos == 3'd0 ? rot : prev;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    assign t   = pos == 3'd0 ? sub ^ {rcon, 24'h0} : (NK == 8 && pos == 3'd4) ? sub : prev;
    assign nxt = rk_word ^ t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = (xfer && rk_idx == IDX_W'(NK - 1)) ? EXPAND : LOAD;
            EXPAND:  state_n = done ? IDLE : EXPAND;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win    <= '0;
            rk_idx <= '0;
            pos    <= '0;
            rcon   <= RCON_RST;
        end else if (state == IDLE && start) begin
            win    <= key_in;
            rk_idx <= '0;
            pos    <= '0;
            rcon   <= RCON_RST;
        end else if (xfer) begin
            if (last) begin
                win    <= '0;
                rk_idx <= '0;
            end else begin
                win    <= {win[KEY_BITS-33:0], nxt};
                rk_idx <= rk_idx + 1'b1;
                pos    <= pos == 3'(NK - 1) ? 3'd0 : pos + 3'd1;
                if (pos == 3'd0) rcon <= xtime(rcon);
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed FIPS-197 vectors against 128/192/256-bit instances.
module tb_aes_key_expand;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 0, rst = 1, start = 0, rk_ready = 0;
    logic [1:0] sel = 0;
    logic [127:0] k128 = KEY_A;
    logic [191:0] k192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    logic [2:0] b, v, d;
    logic [31:0] w [3];
    logic [5:0] x [3];
    logic busy, rv, done;
    logic [31:0] word;
    logic [5:0] idx;
    logic [31:0] known [int];
    int passed = 0, total = 0, kset = 0;

    always #5 clk = ~clk;

    aes_key_expand #(.KEY_BITS(128), .IDX_W(6)) u128 (.clk(clk), .rst(rst), .start(start && sel == 0),
        .key_in(k128), .busy(b[0]), .rk_valid(v[0]), .rk_ready(rk_ready), .rk_word(w[0]), .rk_idx(x[0]), .done(d[0]));
    aes_key_expand #(.KEY_BITS(192), .IDX_W(6)) u192 (.clk(clk), .rst(rst), .start(start && sel == 1),
        .key_in(k192), .busy(b[1]), .rk_valid(v[1]), .rk_ready(rk_ready), .rk_word(w[1]), .rk_idx(x[1]), .done(d[1]));
    aes_key_expand #(.KEY_BITS(256), .IDX_W(6)) u256 (.clk(clk), .rst(rst), .start(start && sel == 2),
        .key_in(k256), .busy(b[2]), .rk_valid(v[2]), .rk_ready(rk_ready), .rk_word(w[2]), .rk_idx(x[2]), .done(d[2]));

    assign busy = b[sel];
    assign rv   = v[sel];
    assign done = d[sel];
    assign word = w[sel];
    assign idx  = x[sel];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got %h want %h", tag, got, exp);
        else passed++;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        check("start_busy", busy, 1);
        check("start_valid", rv, 1);
        check("start_idx", idx, 0);
    endtask

    // Consumes words until `stop` handshakes; poke >= 0 pulses start with KEY_C mid-stream.
    task automatic stream(input int nw, input bit bp, input int poke, input int stop);
        int n = 0, cyc = 0;
        bit poked = 0;
        while (n < stop && cyc < 3000) begin
            @(negedge clk);
            start = 0;
            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n == poke && !poked) begin
                k128 = KEY_C;
                start = 1;
                poked = 1;
            end
            #1;
            cyc++;
            check("valid", rv, 1);
            check("idx", idx, n);
            if (known.exists(kset * 100 + n)) check($sformatf("w%0d", n), word, known[kset * 100 + n]);
            check("done", done, rk_ready && n == nw - 1);
            if (rk_ready) n++;
        end
        start = 0;
        if (n < stop) check("timeout", n, stop);
        if (!bp && stop == nw) check("latency", cyc, nw);
        if (stop == nw) begin
            @(posedge clk);
            #1;
            check("end_busy", busy, 0);
            check("end_valid", rv, 0);
            check("end_idx", idx, 0);
        end
    endtask

    task automatic check_reset();
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            check("rst_busy", busy, 0);
            check("rst_valid", rv, 0);
            check("rst_word", word, 0);
            check("rst_idx", idx, 0);
            check("rst_done", done, 0);
        end
    endtask

    initial begin
        known[0] = 32'h2b7e1516;   known[4] = 32'ha0fafe17;   known[5] = 32'h88542cb1;
        known[6] = 32'h23a33939;   known[7] = 32'h2a6c7605;   known[40] = 32'hd014f9a8;
        known[41] = 32'hc9ee2589;  known[42] = 32'he13f0cc8;  known[43] = 32'hb6630ca6;
        known[100] = 32'h8e73b0f7; known[106] = 32'hfe0c91f7; known[107] = 32'h2402f5a5;
        known[151] = 32'h01002202;
        known[200] = 32'h603deb10; known[208] = 32'h9ba35411; known[209] = 32'h8e6925af;
        known[210] = 32'ha51a8b5f; known[211] = 32'h2067fcde; known[212] = 32'ha8b09c1a;
        known[259] = 32'h706c631e;
        known[300] = 32'h00010203; known[304] = 32'hd6aa74fd; known[340] = 32'h13111d7f;
        known[343] = 32'h4d2b30c5;

        repeat (3) @(posedge clk);
        check_reset();
        @(negedge clk) rst = 0;

        sel = 0; kset = 0; kick(); stream(44, 0, -1, 44);
        sel = 1; kset = 1; kick(); stream(52, 0, -1, 52);
        sel = 2; kset = 2; kick(); stream(60, 0, -1, 60);

        sel = 0; kset = 0; kick(); stream(44, 1, 10, 44);
        kset = 3; kick(); stream(44, 0, -1, 44);

        k128 = KEY_A; kset = 0; kick(); stream(44, 0, -1, 20);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("abort_idx", idx, 0);
        check("abort_valid", rv, 0);
        check("abort_busy", busy, 0);
        check("abort_word", word, 0);
        check("abort_done", done, 0);
        @(negedge clk) rst = 0;
        k128 = KEY_C; kset = 3; kick(); stream(44, 0, -1, 44);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Word-serial AES key-schedule engine. Expands a 128/192/256-bit cipher key into the full FIPS-197 round-key word stream w[0..4·(Nr+1)−1] and delivers one 32-bit word per cycle over a valid/ready handshake. It is the parametrised successor to the fixed 16-bit, 128-bit-only round-key combiner. It feeds the round-based AES datapath or a round-key buffer.

## Interface
Parameters:
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256 (Nk = 4/6/8, Nr = 10/12/14, NW = 44/52/60 words).
- IDX_W, 6, width of the word-index output; must satisfy 2^IDX_W ≥ NW.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin expansion of key_in; sampled only in IDLE.
- key_in  input  KEY_BITS  cipher key; key_in[KEY_BITS-1 -: 32] is w[0] (FIPS-197 byte order).
- busy  output  1  high from the cycle after an accepted start until the last word handshakes.
- rk_valid  output  1  rk_word holds a valid round-key word.
- rk_ready  input  1  consumer accepts rk_word this cycle.
- rk_word  output  32  current round-key word w[rk_idx].
- rk_idx  output  IDX_W  index i of rk_word, 0..NW−1.
- done  output  1  one-cycle pulse in the cycle word NW−1 handshakes.

## Operation
- States: IDLE, LOAD (emit w[0..Nk−1] from the captured key), EXPAND (emit w[Nk..NW−1]), then back to IDLE.
- IDLE plus start: capture key_in into a Nk×32 window register and go to LOAD with idx=0. rcon = 8'h01.
- Handshake: a transfer occurs when rk_valid && rk_ready. On a transfer, idx increments and the window shifts by one word. rk_word and rk_valid are stable while rk_ready is low.
- Expansion for i ≥ Nk: w[i] = w[i−Nk] ^ t, where t = w[i−1], with these cases:
  - i mod Nk == 0: t = SubWord(RotWord(w[i−1])) ^ {rcon, 24'h0}. After use, rcon ← xtime(rcon) = {rcon[6:0],0} ^ (rcon[7] ? 8'h1B : 0).
  - Nk == 8 and i mod 8 == 4: t = SubWord(w[i−1]).
- The next word is computed combinationally from the window and registered on the transfer. No bubbles: one word per cycle while rk_ready stays high.
- LOAD → EXPAND when the transfer of w[Nk−1] occurs. EXPAND → IDLE on the transfer of w[NW−1], with a done pulse.
- start while busy is ignored; key_in is not resampled. start in the same cycle as the final transfer is also ignored. The next start is accepted no earlier than the following cycle.
- Reset mid-expansion aborts immediately. No partial state survives.

## Timing
- Reset values: busy=0, rk_valid=0, rk_word=0, rk_idx=0, done=0, state=IDLE, rcon=8'h01.
- start accepted at edge t: rk_valid=1, rk_word=w[0], busy=1 at t+1.
- Latency from an accepted start to the last word, with rk_ready held high: NW cycles (w[NW−1] is valid at t+NW).
- After the final transfer edge: rk_valid=0, busy=0, rk_idx=0.
- No combinational path from rk_ready to rk_word or rk_idx. The rk_ready → done path is permitted.

## Structure
- Shared package aes_pkg:
  - Nk/Nr/NW derivation functions.
  - xtime function.
  - state enum.
  - Rcon reset constant.
- Sub-module aes_sbox: combinational 8-bit S-box, instantiated 4× for SubWord. It is reused later by the datapath.
- Window register and rcon register live in aes_key_expand. No RAM.

## Test plan
- KEY_BITS=128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1 → w[4]=a0fafe17, w[43]=b6630ca6, done at the 44th word, busy low the next cycle.
- KEY_BITS=192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b → w[6]=fe0c91f7, w[51]=01002202, 52 words total.
- KEY_BITS=256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 → w[8]=9ba35411, w[59]=706c631e. The i mod 8==4 SubWord path is exercised.
- Random rk_ready backpressure (50% duty), 128-bit vector → identical word sequence to the first test. rk_word and rk_idx are held while rk_ready is low.
- start pulsed with a different key at idx=10 → ignored, and the stream still matches the original key. start in the cycle after done → a new expansion begins.
- rst asserted asynchronously at idx=20 → all outputs are at reset values before the next edge. A following start produces w[0] of the new key with rcon restarted at 01.
